// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file for the MIPS datapath.
//   Two write ports (port 1 wins on an address collision), NRD combinational
//   read ports, optional same-cycle write-to-read bypass, optional hardwired
//   zero register, and a one-entry-per-cycle clear sweep reported by ready.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset (restarts the clear sweep)
//   rd_addr  in   NRD packed read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data  out  NRD packed read data,      port k = [k*DATA_W +: DATA_W]
//   we0/waddr0/wdata0  in  write port 0
//   we1/waddr1/wdata1  in  write port 1 (higher priority)
//   clr_req  in   one-cycle request to re-run the clear sweep
//   ready    out  1 = file valid and accepting writes, 0 = sweep in progress
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    input  logic                    we0,
    input  logic [ADDR_W-1:0]       waddr0,
    input  logic [DATA_W-1:0]       wdata0,
    input  logic                    we1,
    input  logic [ADDR_W-1:0]       waddr1,
    input  logic [DATA_W-1:0]       wdata1,
    input  logic                    clr_req,
    output logic                    ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    // Write qualifiers: only in RUN, not on a clr_req edge, never to the
    // hardwired zero entry.
    logic wr_ok;
    logic wr0_go;
    logic wr1_go;

    assign wr_ok  = (state == RUN) && !clr_req;
    assign wr0_go = wr_ok && we0 && !(ZERO_REG && (waddr0 == '0));
    assign wr1_go = wr_ok && we1 && !(ZERO_REG && (waddr1 == '0));

    // Control FSM with registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state   <= RUN;
                        ready   <= 1'b1;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no parallel reset; the sweep zeroes it one entry per edge.
    // Port 1 is written last so it overrides port 0 on an equal address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else begin
                if (wr0_go) mem[waddr0] <= wdata0;
                if (wr1_go) mem[waddr1] <= wdata1;
            end
        end
    end

    // Combinational read ports. Bypass only forwards writes that will
    // actually commit on the coming edge, so it is dead in CLEAR, on a
    // clr_req cycle, and for the zero entry.
    logic [ADDR_W-1:0] ra;

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int k = 0; k < NRD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (state == CLEAR)
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if (ZERO_REG && (ra == '0))
                rd_data[k*DATA_W +: DATA_W] = '0;
            else if (BYPASS && wr1_go && (waddr1 == ra))
                rd_data[k*DATA_W +: DATA_W] = wdata1;
            else if (BYPASS && wr0_go && (waddr0 == ra))
                rd_data[k*DATA_W +: DATA_W] = wdata0;
            else
                rd_data[k*DATA_W +: DATA_W] = mem[ra];
        end
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the MIPS datapath. It is the successor to the single-write/dual-read register file. It adds:
- configurable width, depth and read-port count
- a second write port with defined priority
- optional write-to-read bypass
- an optional hardwired zero register
- a sequential clear sweep that resets the array one entry per cycle, reported by a ready flag

It sits between decode (read addresses) and writeback (write ports) and serves single-cycle and future pipelined cores.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = read returns same-cycle write data on address match; 0 = read returns stored value
ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset; sampled on rising edge of clk
rd_addr  in  NRD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]; combinational
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
clr_req  in  1  single-cycle request to re-run the clear sweep
ready  out  1  1 = file valid and accepting writes; 0 = clear sweep in progress

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high. No asynchronous reset path exists.
- FSM states: CLEAR and RUN, plus a clear index clr_idx[ADDR_W-1:0].
- Reset:
  - rst=1 at an edge forces state=CLEAR, clr_idx=0, ready=0.
  - rst dominates clr_req and all writes.
  - Array contents are not reset in parallel.
- CLEAR:
  - Each edge writes 0 to entry clr_idx, then increments clr_idx.
  - On the edge that clears entry DEPTH-1: state goes to RUN, ready goes to 1, clr_idx wraps to 0.
  - With rst high at edge E0 and low afterwards, entries are cleared on E1..E(DEPTH). ready=1 from just after E(DEPTH), i.e. 32 cycles at default.
  - In CLEAR, we0/we1 are ignored and clr_req is ignored.
  - In CLEAR, all rd_data = 0 regardless of address or bypass.
  - rst reasserted mid-sweep restarts the sweep at index 0.
- RUN:
  - clr_req=1 at an edge moves to CLEAR with clr_idx=0 and ready=0.
  - Writes presented on that same edge are discarded.
- Writes (RUN, clr_req=0):
  - On the edge, if weN=1, then entry waddrN <= wdataN.
  - If both ports are enabled with equal addresses, port 1 wins; port 0 is dropped.
  - If addresses differ, both writes commit.
  - ZERO_REG=1: writes to address 0 are dropped on either port.
- Reads (combinational, per port k):
  - State CLEAR: result is 0.
  - ZERO_REG=1 and rd_addr_k=0: result is 0.
  - BYPASS=1 and we1=1 and waddr1=rd_addr_k: result is wdata1.
  - BYPASS=1 and we0=1 and waddr0=rd_addr_k: result is wdata0.
  - Otherwise: the stored entry.
  - Bypass never forwards to address 0 when ZERO_REG=1.
  - Bypass is inactive in CLEAR or when clr_req=1.
- Latency: write-to-read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0. The clear sweep takes DEPTH cycles.
- Widths: no arithmetic; data is passed unmodified. Addresses are full-range, so no out-of-range case exists.
- ready changes only on clock edges.

Test Plan:
- Reset sweep:
  - Stimulus: rst=1 for 1 edge, then 0; issue we0=1 waddr0=5 wdata0=32'hDEAD during the sweep.
  - Required: ready=0 for exactly 32 edges, then 1; reg 5 reads 0 after ready (write ignored); all reads 0 during the sweep.
- Dual-write collision:
  - Stimulus: in RUN, we0=we1=1, waddr0=waddr1=7, wdata0=32'h1111, wdata1=32'h2222.
  - Required: next cycle rd_addr=7 reads 32'h2222.
  - Second stimulus: waddr0=3, waddr1=4 with the same data.
  - Required: both commit.
- Bypass:
  - Stimulus: BYPASS=1, we0=1 waddr0=9 wdata0=32'hCAFE, rd_addr port0=9 in the same cycle.
  - Required: rd_data0=32'hCAFE before the edge.
  - Repeat with BYPASS=0: rd_data0 shows the old value until after the edge.
- Zero register:
  - Stimulus: ZERO_REG=1, we1=1 waddr1=0 wdata1=32'hFFFF_FFFF, read port1 addr 0.
  - Required: reads 0 in the same cycle and the next cycle.
- clr_req mid-run:
  - Stimulus: load reg 12=32'hABCD; pulse clr_req with we0=1 waddr0=13 wdata0=32'h1 on the same edge.
  - Required: ready=0 for 32 edges; afterwards reg 12=0 and reg 13=0.
- rst mid-sweep:
  - Stimulus: assert rst at sweep index 10.
  - Required: sweep restarts; ready rises 32 edges after rst deasserts.
